// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain_driver: runs a configurable number of ap_ctrl_chain
// transactions against a block, issuing ap_start and paced ap_continue
// handshakes, counting both sides and flagging done pulses that have no
// outstanding start behind them.
// Optional feature: define DRIVER_LATENCY_STATS_EN to add a timestamp FIFO
// (OUTST deep) that measures start-to-done latency and throttles issuing
// when OUTST transactions are in flight.
module ap_ctrl_chain_driver #(
  parameter int NUM_W = 16,
  parameter int CNT_W = 32,
  parameter int OUTST = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_go,
  input  logic [NUM_W-1:0] cfg_num_txn,
  input  logic [7:0]       cfg_cont_delay,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             run_done,
  output logic [NUM_W-1:0] txn_issued,
  output logic [NUM_W-1:0] txn_done,
  output logic             protocol_err,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NUM_W-1:0] num;
  logic [7:0]       delay;
  logic [7:0]       hold_cnt;
  logic             go_acc;
  logic             start_hs;
  logic             done_hs;
  logic             spurious;
  logic             done_ok;
  logic             fifo_full;
  logic [NUM_W-1:0] issued_nxt;
  logic [NUM_W-1:0] done_nxt;

  // A done with nothing outstanding is only legal when a start lands in the
  // same cycle (zero-latency block); otherwise it is a protocol violation
  // and must not be counted.
  assign go_acc     = (state == IDLE) && cfg_go;
  assign start_hs   = ap_start && ap_ready;
  assign done_hs    = ap_done && ap_continue;
  assign spurious   = done_hs && (txn_done == txn_issued) && !start_hs;
  assign done_ok    = done_hs && !spurious;
  assign issued_nxt = start_hs ? txn_issued + NUM_W'(1) : txn_issued;
  assign done_nxt   = done_ok  ? txn_done   + NUM_W'(1) : txn_done;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; counts are compared on their post-edge values so a
  // final start and final done landing together go straight to FINISH.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_go) begin
          state_nxt = (cfg_num_txn == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (issued_nxt == num) begin
          state_nxt = (done_nxt == num) ? FINISH : DRAIN;
        end
      end
      DRAIN: begin
        if (done_nxt == num) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode, purely from registered state so reset clears it at once
  always_comb begin
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    busy        = 1'b0;
    run_done    = 1'b0;
    case (state)
      ISSUE: begin
        ap_start    = (txn_issued < num) && !fifo_full;
        ap_continue = (hold_cnt == 8'd0);
        busy        = 1'b1;
      end
      DRAIN: begin
        ap_continue = (hold_cnt == 8'd0);
        busy        = 1'b1;
      end
      FINISH: begin
        busy     = 1'b1;
        run_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Run configuration, captured only when a run is accepted
  always_ff @(posedge clock) begin
    if (go_acc) begin
      num   <= cfg_num_txn;
      delay <= cfg_cont_delay;
    end
  end

  // Handshake counters, continue hold-off and sticky protocol error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txn_issued   <= '0;
      txn_done     <= '0;
      hold_cnt     <= 8'd0;
      protocol_err <= 1'b0;
    end else if (go_acc) begin
      txn_issued   <= '0;
      txn_done     <= '0;
      hold_cnt     <= 8'd0;
      protocol_err <= 1'b0;
    end else begin
      txn_issued <= issued_nxt;
      txn_done   <= done_nxt;
      if (spurious) begin
        protocol_err <= 1'b1;
      end
      if (done_ok) begin
        hold_cnt <= delay;
      end else if (hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

`ifdef DRIVER_LATENCY_STATS_EN
  // Pointer width; storage is rounded to a power of two so pointers wrap
  // naturally even for a depth of one.
  localparam int AW = (OUTST > 1) ? $clog2(OUTST) : 1;

  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ts_mem [2**AW];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic             fifo_empty;
  logic             bypass;
  logic [CNT_W-1:0] lat_now;

  // Elapsed cycles between two counter samples, modulo the counter width
  function automatic logic [CNT_W-1:0] lat_diff(input logic [CNT_W-1:0] now_c,
                                                input logic [CNT_W-1:0] then_c);
    return now_c - then_c;
  endfunction

  // A start and its done in the same cycle on an empty FIFO never touch
  // storage; that transaction took zero cycles.
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(OUTST));
  assign bypass     = fifo_empty && start_hs && done_ok;
  assign lat_now    = fifo_empty ? '0 : lat_diff(cyc_cnt, ts_mem[rd_ptr]);

  // Timestamp storage
  always_ff @(posedge clock) begin
    if (start_hs && !bypass) begin
      ts_mem[wr_ptr] <= cyc_cnt;
    end
  end

  // Cycle counter, FIFO pointers and latency statistics
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      last_latency <= '0;
      max_latency  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (go_acc) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fifo_cnt    <= '0;
        max_latency <= '0;
      end else begin
        if (!bypass) begin
          if (start_hs) begin
            wr_ptr <= wr_ptr + AW'(1);
          end
          if (done_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
          end
          if (start_hs && !done_ok) begin
            fifo_cnt <= fifo_cnt + (AW+1)'(1);
          end else if (!start_hs && done_ok) begin
            fifo_cnt <= fifo_cnt - (AW+1)'(1);
          end
        end
        if (done_ok) begin
          last_latency <= lat_now;
          if (lat_now > max_latency) begin
            max_latency <= lat_now;
          end
        end
      end
    end
  end
`else
  // No timestamp FIFO: issuing is never throttled (the expression is
  // constant low for every legal depth) and no latency is measured.
  assign fifo_full    = (OUTST < 1);
  assign last_latency = '0;
  assign max_latency  = '0;
`endif

endmodule

// File: doc/ap_ctrl_chain_driver.md
AP_CTRL_CHAIN_DRIVER -- requirements
Module: ap_ctrl_chain_driver

Interface
REQ-001 SHALL have parameter NUM_W, default 16, width of transaction count and count outputs.
REQ-002 SHALL have parameter CNT_W, default 32, width of cycle counter and latency outputs.
REQ-003 SHALL have parameter OUTST, default 4, timestamp FIFO depth (power of 2), used only when LAT_STATS compiled in.
REQ-004 Ports, name direction width meaning; one clock, reset asynchronous and active-high:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cfg_go  in  1  start-run pulse, sampled in IDLE only.
- cfg_num_txn  in  NUM_W  transactions per run, latched on accepted cfg_go.
- cfg_cont_delay  in  8  ap_continue hold-off cycles after each done handshake, latched on accepted cfg_go.
- ap_start  out  1  block start request to DUT.
- ap_ready  in  1  DUT accepted inputs.
- ap_done  in  1  DUT output valid.
- ap_continue  out  1  driver accepts DUT output.
- busy  out  1  high in any state except IDLE.
- run_done  out  1  one-cycle pulse at run completion.
- txn_issued  out  NUM_W  start handshakes this run.
- txn_done  out  NUM_W  done handshakes this run.
- protocol_err  out  1  sticky; ap_done&ap_continue with txn_done==txn_issued and no same-cycle start handshake.
- last_latency  out  CNT_W  cycles from start handshake to matching done handshake.
- max_latency  out  CNT_W  maximum last_latency this run.

Function
REQ-005 FSM states IDLE, ISSUE, DRAIN, FINISH; SHALL encode no others.
REQ-006 IDLE: cfg_go=1 -> latch config, clear txn_issued, txn_done, protocol_err, max_latency; next ISSUE, or FINISH if cfg_num_txn==0.
REQ-007 ap_start SHALL be combinational from registers: (state==ISSUE) && txn_issued<num && !fifo_full.
REQ-008 Start handshake = ap_start&ap_ready; SHALL increment txn_issued; ap_start stays high until handshake (never withdrawn unaccepted).
REQ-009 ISSUE -> DRAIN on the edge where txn_issued reaches num.
REQ-010 ap_continue SHALL be (state==ISSUE||state==DRAIN) && hold_cnt==0.
REQ-011 Done handshake = ap_done&ap_continue; SHALL increment txn_done and load hold_cnt with cfg_cont_delay; hold_cnt decrements to 0 each cycle.
REQ-012 DRAIN -> FINISH on the edge where txn_done reaches num; FINISH -> IDLE after one cycle; run_done=1 exactly in FINISH.
REQ-013 Same-cycle start and done handshakes SHALL both be counted.
REQ-014 Spurious done (per protocol_err definition) SHALL set protocol_err and leave txn_done unchanged.
REQ-015 cfg_go outside IDLE SHALL be ignored.
REQ-016 Free-running cycle counter width CNT_W, wraps; latency = now - pushed timestamp, modulo 2^CNT_W.

Reset
REQ-017 reset SHALL asynchronously force IDLE, hold_cnt 0, cycle counter 0, FIFO empty, and every output 0 (ap_start, ap_continue deassert immediately), including mid-run.
REQ-018 After reset release no handshake SHALL occur before an accepted cfg_go.

Configuration
REQ-019 Macro DRIVER_LATENCY_STATS_EN defined: OUTST-deep timestamp FIFO pushes cycle count on start handshake, pops on done handshake; last_latency/max_latency update on pop; fifo_full gates ap_start; empty FIFO with same-cycle push and pop yields latency 0.
REQ-020 Macro undefined: no FIFO or cycle counter, fifo_full constant 0, last_latency and max_latency tied 0.

Verification
REQ-021 num=3, delay=0, DUT ready same cycle as start, done 5 cycles later -> txn_issued=3, txn_done=3, run_done one pulse, last_latency=5, max_latency=5, protocol_err=0.
REQ-022 num=0, cfg_go -> busy one cycle (FINISH), run_done pulse, no ap_start ever.
REQ-023 delay=3, DUT asserts done continuously -> ap_continue high 1 cycle then low exactly 3 cycles, repeating.
REQ-024 Stats on, OUTST=4, DUT never asserts done -> exactly 4 start handshakes then ap_start stays 0; release done -> issuing resumes.
REQ-025 ap_done pulse in IDLE-free window with txn_done==txn_issued -> protocol_err=1, txn_done unchanged, stays set until next accepted cfg_go.
REQ-026 reset asserted mid-DRAIN -> same-cycle ap_start=0, ap_continue=0, all counts 0; new cfg_go runs normally.
